fmt_grant_ctrl: RTL and testbench



---
 rtl/mcdf_pkg.sv | 20 ++
 rtl/fmt_credit_cnt.sv | 54 +++++
 rtl/fmt_grant_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fmt_grant_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcdf_pkg.sv
// Shared types and constants for the MCDF formatter output path.
package mcdf_pkg;

  localparam int LEN_W          = 6;
  localparam int CHID_W         = 2;
  localparam int CREDIT_MAX_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_RECV       = 2'd2,
    ST_DRAIN      = 2'd3
  } state_e;

  // A request length is legal when non-zero and no larger than the sink buffer.
  function automatic logic len_valid(input logic [LEN_W-1:0] len, input int max_words);
    return (len != {LEN_W{1'b0}}) && (int'(len) <= max_words);
  endfunction

endpackage

// File: rtl/fmt_credit_cnt.sv
// Saturating sink-credit counter: reserve on grant, refund on short/aborted
// packets, one-word return from the sink; flags overflow beyond CREDIT_MAX.
module fmt_credit_cnt
  import mcdf_pkg::*;
#(
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int CNT_W      = 7
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             reserve_i,
  input  logic [CNT_W-1:0] reserve_amt_i,
  input  logic             refund_i,
  input  logic [CNT_W-1:0] refund_amt_i,
  input  logic             ret_i,
  output logic [CNT_W-1:0] credit_o,
  output logic             ovf_o
);

  localparam logic [CNT_W:0]   MAX_EXT = (CNT_W+1)'(CREDIT_MAX);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDIT_MAX);

  logic [CNT_W-1:0] credit_r;
  logic [CNT_W-1:0] credit_next_s;
  logic [CNT_W:0]   sum_s;
  logic [CNT_W:0]   rsv_s;
  logic [CNT_W:0]   rfd_s;

  // Combine all same-cycle adjustments, then saturate at the buffer depth.
  always_comb begin
    rsv_s = reserve_i ? {1'b0, reserve_amt_i} : {(CNT_W+1){1'b0}};
    rfd_s = refund_i  ? {1'b0, refund_amt_i}  : {(CNT_W+1){1'b0}};
    sum_s = {1'b0, credit_r} - rsv_s + rfd_s + {{CNT_W{1'b0}}, ret_i};
    if (sum_s > MAX_EXT) begin
      credit_next_s = MAX_CNT;
      ovf_o         = 1'b1;
    end else begin
      credit_next_s = sum_s[CNT_W-1:0];
      ovf_o         = 1'b0;
    end
  end

  // Credit register, full at reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      credit_r <= MAX_CNT;
    end else begin
      credit_r <= credit_next_s;
    end
  end

  assign credit_o = credit_r;

endmodule

// File: rtl/fmt_grant_ctrl.sv
// Formatter grant controller: credit-gated grant, beat forwarding to the sink
// with SOP/EOP marking, and sticky protocol error flags.
module fmt_grant_ctrl
  import mcdf_pkg::*;
#(
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int START_TO   = 15,
  parameter int CNT_W      = 7
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              fmt_req_i,
  input  logic [CHID_W-1:0] fmt_chid_i,
  input  logic [LEN_W-1:0]  fmt_length_i,
  input  logic [31:0]       fmt_data_i,
  input  logic              fmt_start_i,
  input  logic              fmt_end_i,
  output logic              fmt_grant_o,
  output logic              ds_vld_o,
  output logic [31:0]       ds_data_o,
  output logic [CHID_W-1:0] ds_chid_o,
  output logic              ds_sop_o,
  output logic              ds_eop_o,
  input  logic              ds_credit_ret_i,
  output logic [CNT_W-1:0]  credit_o,
  input  logic              err_clr_i,
  output logic              err_len_o,
  output logic              err_to_o,
  output logic              err_crd_o
);

  localparam int               TMR_W   = $clog2(START_TO + 1);
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(START_TO - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_r;
  logic [LEN_W-1:0]  len_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [TMR_W-1:0]  tmr_r;
  logic              grant_r;
  logic              ds_vld_r;
  logic [31:0]       ds_data_r;
  logic [CHID_W-1:0] ds_chid_r;
  logic              ds_sop_r;
  logic              ds_eop_r;
  logic              err_len_r;
  logic              err_to_r;
  logic              err_crd_r;

  logic [CNT_W-1:0]  credit_s;
  logic              crd_ovf_s;
  logic [CNT_W-1:0]  req_len_s;
  logic [CNT_W-1:0]  lat_len_s;
  logic              len_bad_s;
  logic              grant_s;
  logic              beat_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              cnt_hit_s;
  logic              timeout_s;
  logic              refund_s;
  logic [CNT_W-1:0]  refund_amt_s;

  // Per-cycle decisions shared by the FSM and the credit counter.
  always_comb begin
    req_len_s  = CNT_W'(fmt_length_i);
    lat_len_s  = CNT_W'(len_r);
    len_bad_s  = fmt_req_i && !len_valid(fmt_length_i, CREDIT_MAX);
    grant_s    = (state_r == ST_IDLE) && fmt_req_i && !len_bad_s && (req_len_s <= credit_s);
    beat_s     = ((state_r == ST_WAIT_START) && fmt_start_i) || (state_r == ST_RECV);
    cnt_next_s = (state_r == ST_WAIT_START) ? CNT_ONE : (cnt_r + CNT_ONE);
    cnt_hit_s  = beat_s && (cnt_next_s == lat_len_s);
    timeout_s  = (state_r == ST_WAIT_START) && !fmt_start_i && (tmr_r == TO_LAST);
    if (timeout_s) begin
      refund_s     = 1'b1;
      refund_amt_s = lat_len_s;
    end else if (beat_s && fmt_end_i && (cnt_next_s < lat_len_s)) begin
      refund_s     = 1'b1;
      refund_amt_s = lat_len_s - cnt_next_s;
    end else begin
      refund_s     = 1'b0;
      refund_amt_s = {CNT_W{1'b0}};
    end
  end

  fmt_credit_cnt #(
    .CREDIT_MAX (CREDIT_MAX),
    .CNT_W      (CNT_W)
  ) u_credit (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .reserve_i     (grant_s),
    .reserve_amt_i (req_len_s),
    .refund_i      (refund_s),
    .refund_amt_i  (refund_amt_s),
    .ret_i         (ds_credit_ret_i),
    .credit_o      (credit_s),
    .ovf_o         (crd_ovf_s)
  );

  // Packet FSM with registered grant, forwarding and error outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r   <= ST_IDLE;
      len_r     <= {LEN_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      tmr_r     <= {TMR_W{1'b0}};
      grant_r   <= 1'b0;
      ds_vld_r  <= 1'b0;
      ds_data_r <= 32'h0000_0000;
      ds_chid_r <= {CHID_W{1'b0}};
      ds_sop_r  <= 1'b0;
      ds_eop_r  <= 1'b0;
      err_len_r <= 1'b0;
      err_to_r  <= 1'b0;
      err_crd_r <= 1'b0;
    end else begin
      grant_r  <= 1'b0;
      ds_vld_r <= 1'b0;
      ds_sop_r <= 1'b0;
      ds_eop_r <= 1'b0;
      // Clear first so that any set below in the same cycle takes priority.
      if (err_clr_i) begin
        err_len_r <= 1'b0;
        err_to_r  <= 1'b0;
        err_crd_r <= 1'b0;
      end
      if (crd_ovf_s) begin
        err_crd_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            grant_r   <= 1'b1;
            len_r     <= fmt_length_i;
            ds_chid_r <= fmt_chid_i;
            tmr_r     <= {TMR_W{1'b0}};
            state_r   <= ST_WAIT_START;
          end else if (len_bad_s) begin
            err_len_r <= 1'b1;
          end
        end
        ST_WAIT_START, ST_RECV: begin
          if (beat_s) begin
            ds_vld_r  <= 1'b1;
            ds_data_r <= fmt_data_i;
            ds_sop_r  <= (state_r == ST_WAIT_START);
            cnt_r     <= cnt_next_s;
            if (fmt_end_i) begin
              ds_eop_r <= 1'b1;
              if (cnt_next_s != lat_len_s) begin
                err_len_r <= 1'b1;
              end
              state_r <= ST_IDLE;
            end else if (cnt_hit_s) begin
              ds_eop_r  <= 1'b1;
              err_len_r <= 1'b1;
              state_r   <= ST_DRAIN;
            end else begin
              state_r <= ST_RECV;
            end
          end else if (timeout_s) begin
            err_to_r <= 1'b1;
            state_r  <= ST_IDLE;
          end else begin
            tmr_r <= tmr_r + TMR_ONE;
          end
        end
        ST_DRAIN: begin
          if (fmt_end_i) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign fmt_grant_o = grant_r;
  assign ds_vld_o    = ds_vld_r;
  assign ds_data_o   = ds_data_r;
  assign ds_chid_o   = ds_chid_r;
  assign ds_sop_o    = ds_sop_r;
  assign ds_eop_o    = ds_eop_r;
  assign credit_o    = credit_s;
  assign err_len_o   = err_len_r;
  assign err_to_o    = err_to_r;
  assign err_crd_o   = err_crd_r;

endmodule

// File: tb/tb_fmt_grant_ctrl.sv
// Scoreboard bench for fmt_grant_ctrl: stimulus pushes expected beats/grants,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_fmt_grant_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  chid;
    logic        sop;
    logic        eop;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fmt_req = 1'b0;
  logic [1:0]  fmt_chid = 2'd0;
  logic [5:0]  fmt_length = 6'd0;
  logic [31:0] fmt_data = 32'h0;
  logic        fmt_start = 1'b0;
  logic        fmt_end = 1'b0;
  logic        fmt_grant;
  logic        ds_vld;
  logic [31:0] ds_data;
  logic [1:0]  ds_chid;
  logic        ds_sop;
  logic        ds_eop;
  logic        ds_credit_ret = 1'b0;
  logic [6:0]  credit;
  logic        err_clr = 1'b0;
  logic        err_len;
  logic        err_to;
  logic        err_crd;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t      exp_q[$];
  logic [6:0] grant_q[$];
  beat_t      mon_exp;
  beat_t      mon_got;
  logic [6:0] mon_cr;

  fmt_grant_ctrl dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .fmt_req_i       (fmt_req),
    .fmt_chid_i      (fmt_chid),
    .fmt_length_i    (fmt_length),
    .fmt_data_i      (fmt_data),
    .fmt_start_i     (fmt_start),
    .fmt_end_i       (fmt_end),
    .fmt_grant_o     (fmt_grant),
    .ds_vld_o        (ds_vld),
    .ds_data_o       (ds_data),
    .ds_chid_o       (ds_chid),
    .ds_sop_o        (ds_sop),
    .ds_eop_o        (ds_eop),
    .ds_credit_ret_i (ds_credit_ret),
    .credit_o        (credit),
    .err_clr_i       (err_clr),
    .err_len_o       (err_len),
    .err_to_o        (err_to),
    .err_crd_o       (err_crd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every presented beat or grant must match the head of its queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (ds_vld) begin
        mon_got = '{data: ds_data, chid: ds_chid, sop: ds_sop, eop: ds_eop};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got %h, expected none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("beat", 64'(mon_got), 64'(mon_exp));
        end
      end
      if (fmt_grant) begin
        if (grant_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL grant_unexpected: got grant with credit %0d, expected none", credit);
        end else begin
          mon_cr = grant_q.pop_front();
          chk("grant_credit", 64'(credit), 64'(mon_cr));
        end
      end
    end
  end

  task automatic do_req(input int len, input int chid, input int exp_cr);
    logic got;
    got = 1'b0;
    grant_q.push_back(7'(exp_cr));
    fmt_req = 1'b1;
    fmt_length = 6'(len);
    fmt_chid = 2'(chid);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fmt_grant) begin
        got = 1'b1;
        break;
      end
    end
    fmt_req = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: got no grant, expected grant for len %0d", len);
      void'(grant_q.pop_back());
    end
  endtask

  task automatic send_pkt(input int n_beats, input int end_beat, input int len,
                          input int chid, input logic [31:0] base);
    for (int i = 1; i <= n_beats; i++) begin
      fmt_start = (i == 1);
      fmt_end   = (i == end_beat);
      fmt_data  = base + 32'(i);
      if (i <= len && i <= end_beat)
        exp_q.push_back('{data: base + 32'(i), chid: 2'(chid), sop: (i == 1),
                          eop: (i == end_beat) || (i == len)});
      @(negedge clk);
    end
    fmt_start = 1'b0;
    fmt_end   = 1'b0;
    fmt_data  = 32'h0;
  endtask

  task automatic ret_n(input int n);
    for (int i = 0; i < n; i++) begin
      ds_credit_ret = 1'b1;
      @(negedge clk);
    end
    ds_credit_ret = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_credit", 64'(credit), 64'd64);
    chk("rst_outs", {ds_vld, ds_sop, ds_eop, fmt_grant, err_len, err_to, err_crd}, 64'd0);
    chk("rst_data", {ds_data, ds_chid}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: basic packet
    do_req(8, 2, 56);
    chk("t1_chid", 64'(ds_chid), 64'd2);
    send_pkt(8, 8, 8, 2, 32'hA100_0000);
    chk("t1_credit", 64'(credit), 64'd56);
    chk("t1_errs", {err_len, err_to, err_crd}, 64'd0);

    // 2: drain to 4, then wait for returns before granting 16
    do_req(32, 1, 24);
    send_pkt(32, 32, 32, 1, 32'hA200_0000);
    do_req(20, 0, 4);
    send_pkt(20, 20, 20, 0, 32'hA300_0000);
    chk("t2_credit4", 64'(credit), 64'd4);
    grant_q.push_back(7'd0);
    fmt_req = 1'b1;
    fmt_length = 6'd16;
    fmt_chid = 2'd1;
    repeat (3) @(negedge clk);
    chk("t2_nogrant", 64'(fmt_grant), 64'd0);
    ret_n(12);
    chk("t2_credit16", 64'(credit), 64'd16);
    chk("t2_nogrant_at15", 64'(fmt_grant), 64'd0);
    waited = 0;
    while (!fmt_grant && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    fmt_req = 1'b0;
    chk("t2_grant_latency", 64'(waited), 64'd1);
    send_pkt(16, 16, 16, 1, 32'hA400_0000);
    chk("t2_credit0", 64'(credit), 64'd0);
    ret_n(64);
    chk("t2_credit64", 64'(credit), 64'd64);
    chk("t2_no_crd_err", 64'(err_crd), 64'd0);

    // 3: short packet, refund 1, then clear
    do_req(4, 1, 60);
    send_pkt(3, 3, 4, 1, 32'hA500_0000);
    chk("t3_err_len", 64'(err_len), 64'd1);
    chk("t3_credit", 64'(credit), 64'd61);
    clr_err();
    chk("t3_err_clr", 64'(err_len), 64'd0);
    ret_n(3);

    // 4: long packet, beats 5-6 dropped
    do_req(4, 3, 60);
    send_pkt(6, 6, 4, 3, 32'hA600_0000);
    chk("t4_err_len", 64'(err_len), 64'd1);
    chk("t4_credit", 64'(credit), 64'd60);
    clr_err();
    ret_n(4);
    chk("t4_credit64", 64'(credit), 64'd64);

    // zero length: error, no grant
    fmt_req = 1'b1;
    fmt_length = 6'd0;
    repeat (2) @(negedge clk);
    fmt_req = 1'b0;
    chk("len0_err", 64'(err_len), 64'd1);
    chk("len0_credit", 64'(credit), 64'd64);
    clr_err();

    // 5: start timeout
    do_req(32, 0, 32);
    repeat (14) @(negedge clk);
    chk("t5_no_to_yet", 64'(err_to), 64'd0);
    @(negedge clk);
    chk("t5_err_to", 64'(err_to), 64'd1);
    chk("t5_credit", 64'(credit), 64'd64);
    do_req(10, 2, 54);
    send_pkt(10, 10, 10, 2, 32'hA700_0000);
    ret_n(10);
    clr_err();
    chk("t5_to_clr", 64'(err_to), 64'd0);

    // 6: return overflow, then reset mid-packet
    chk("t6_credit64", 64'(credit), 64'd64);
    ret_n(1);
    chk("t6_credit_sat", 64'(credit), 64'd64);
    chk("t6_err_crd", 64'(err_crd), 64'd1);
    do_req(8, 2, 56);
    send_pkt(3, 99, 8, 2, 32'hA800_0000);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_credit", 64'(credit), 64'd64);
    chk("t6_rst_outs", {ds_vld, ds_sop, ds_eop, fmt_grant, err_len, err_to, err_crd}, 64'd0);
    chk("t6_rst_data", {ds_data, ds_chid}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_req(8, 1, 56);
    send_pkt(8, 8, 8, 1, 32'hA900_0000);
    chk("post_rst_credit", 64'(credit), 64'd56);

    repeat (2) @(negedge clk);
    chk("beat_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("grant_queue_empty", 64'(grant_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
